// File: rtl/oled_rx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : oled_rx_pkg
// Brief    : Shared opcodes, parser states and geometry for the OLED SPI rx.
// Revision : 1.0 - initial release
// ============================================================================
package oled_rx_pkg;

  localparam int COLS     = 128;
  localparam int PAGES    = 4;
  localparam int FB_DEPTH = COLS * PAGES;
  localparam int FB_AW    = $clog2(FB_DEPTH);

  localparam logic [7:0] CMD_MEM_MODE  = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } parser_state_e;

  // Commands whose single argument is swallowed without effect on this model.
  function automatic logic is_one_arg_cmd(input logic [7:0] op);
    logic hit;
    case (op)
      8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: hit = 1'b1;
      default:                                                hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_rx_framebuf.sv
`default_nettype none
// ============================================================================
// Module   : oled_rx_framebuf
// Brief    : 512x8 simple dual-port RAM, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module oled_rx_framebuf
  import oled_rx_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = FB_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rd_data
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read-before-write: a same-cycle read of the written address returns old data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_mem[raddr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : oled_spi_rx
// Brief    : SSD1306 SPI receive decoder with a 128x32 shadow frame buffer.
//            Define OLED_SPI_RX_STATS_EN to add cmd_count/data_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module oled_spi_rx
  import oled_rx_pkg::*;
#(
  parameter int IDLE_CLKS = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        oled_sclk,
  input  logic        oled_sdin,
  input  logic        oled_dc,
  input  logic        oled_res,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        disp_on,
  output logic        frame_done,
  input  logic [8:0]  rd_addr,
  output logic [7:0]  rd_data
`ifdef OLED_SPI_RX_STATS_EN
  ,
  output logic [15:0] cmd_count,
  output logic [15:0] data_count
`endif
);

  localparam int         c_IDLE_W   = $clog2(IDLE_CLKS + 1);
  localparam logic [3:0] c_SYNC_RST = 4'b1001;  // {res, dc, sdin, sclk}: pins idle

  // ---------------------------------------------------------------- front end
  logic [3:0]          r_meta;
  logic [3:0]          r_sync;
  logic                r_sclk_prev;
  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic [2:0]          r_bit_cnt;
  logic [6:0]          r_shift;
  logic                r_byte_valid;
  logic [7:0]          r_byte_data;
  logic                r_byte_is_data;

  logic w_sclk;
  logic w_sdin;
  logic w_dc;
  logic w_res_active;
  logic w_rise;
  logic w_idle_hit;

  assign w_sclk       = r_sync[0];
  assign w_sdin       = r_sync[1];
  assign w_dc         = r_sync[2];
  assign w_res_active = ~r_sync[3];
  assign w_rise       = w_sclk & ~r_sclk_prev;
  assign w_idle_hit   = w_sclk && (r_idle_cnt == c_IDLE_W'(IDLE_CLKS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta         <= c_SYNC_RST;
      r_sync         <= c_SYNC_RST;
      r_sclk_prev    <= 1'b1;
      r_idle_cnt     <= '0;
      r_bit_cnt      <= 3'd0;
      r_shift        <= 7'd0;
      r_byte_valid   <= 1'b0;
      r_byte_data    <= 8'h00;
      r_byte_is_data <= 1'b0;
    end else begin
      r_meta       <= {oled_res, oled_dc, oled_sdin, oled_sclk};
      r_sync       <= r_meta;
      r_sclk_prev  <= w_sclk;
      r_byte_valid <= 1'b0;

      if (!w_sclk || w_rise) begin
        r_idle_cnt <= '0;
      end else if (!w_idle_hit) begin
        r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
      end

      // A long SCLK-high gap or a display reset realigns to a byte boundary.
      if (w_res_active || w_idle_hit) begin
        r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
        r_shift   <= {r_shift[5:0], w_sdin};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte_valid   <= 1'b1;
          r_byte_data    <= {r_shift, w_sdin};
          r_byte_is_data <= w_dc;
        end
      end
    end
  end

  // ---------------------------------------------------------------- parser
  parser_state_e r_state,     w_nxt_state;
  logic [7:0]    r_op,        w_nxt_op;
  logic [6:0]    r_arg1,      w_nxt_arg1;
  logic          r_horiz,     w_nxt_horiz;
  logic [6:0]    r_col_start, w_nxt_col_start;
  logic [6:0]    r_col_end,   w_nxt_col_end;
  logic [1:0]    r_page_start, w_nxt_page_start;
  logic [1:0]    r_page_end,  w_nxt_page_end;
  logic [6:0]    r_col,       w_nxt_col;
  logic [1:0]    r_page,      w_nxt_page;
  logic          r_disp_on,   w_nxt_disp_on;
  logic          w_fb_we;
  logic          w_frame_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_op         <= 8'h00;
      r_arg1       <= 7'd0;
      r_horiz      <= 1'b0;
      r_col_start  <= 7'd0;
      r_col_end    <= 7'(COLS - 1);
      r_page_start <= 2'd0;
      r_page_end   <= 2'(PAGES - 1);
      r_col        <= 7'd0;
      r_page       <= 2'd0;
      r_disp_on    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_op         <= w_nxt_op;
      r_arg1       <= w_nxt_arg1;
      r_horiz      <= w_nxt_horiz;
      r_col_start  <= w_nxt_col_start;
      r_col_end    <= w_nxt_col_end;
      r_page_start <= w_nxt_page_start;
      r_page_end   <= w_nxt_page_end;
      r_col        <= w_nxt_col;
      r_page       <= w_nxt_page;
      r_disp_on    <= w_nxt_disp_on;
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_op         = r_op;
    w_nxt_arg1       = r_arg1;
    w_nxt_horiz      = r_horiz;
    w_nxt_col_start  = r_col_start;
    w_nxt_col_end    = r_col_end;
    w_nxt_page_start = r_page_start;
    w_nxt_page_end   = r_page_end;
    w_nxt_col        = r_col;
    w_nxt_page       = r_page;
    w_nxt_disp_on    = r_disp_on;
    w_fb_we          = 1'b0;
    w_frame_done     = 1'b0;

    if (w_res_active) begin
      w_nxt_state      = ST_IDLE;
      w_nxt_horiz      = 1'b0;
      w_nxt_col_start  = 7'd0;
      w_nxt_col_end    = 7'(COLS - 1);
      w_nxt_page_start = 2'd0;
      w_nxt_page_end   = 2'(PAGES - 1);
      w_nxt_col        = 7'd0;
      w_nxt_page       = 2'd0;
      w_nxt_disp_on    = 1'b0;
    end else if (r_byte_valid) begin
      if (r_byte_is_data) begin
        // Data always lands, even if it interrupts a pending command.
        w_nxt_state = ST_IDLE;
        w_fb_we     = 1'b1;
        if (r_col == r_col_end) begin
          w_nxt_col = r_col_start;
          if (r_horiz) begin
            if (r_page == r_page_end) begin
              w_nxt_page   = r_page_start;
              w_frame_done = 1'b1;
            end else begin
              w_nxt_page = r_page + 2'd1;
            end
          end
        end else begin
          w_nxt_col = r_col + 7'd1;
        end
      end else begin
        w_nxt_state = ST_IDLE;
        case (r_state)
          ST_IDLE: begin
            w_nxt_op = r_byte_data;
            if (r_byte_data == CMD_MEM_MODE || r_byte_data == CMD_COL_ADDR ||
                r_byte_data == CMD_PAGE_ADDR || is_one_arg_cmd(r_byte_data)) begin
              w_nxt_state = ST_ARG1;
            end else if (r_byte_data == CMD_DISP_OFF) begin
              w_nxt_disp_on = 1'b0;
            end else if (r_byte_data == CMD_DISP_ON) begin
              w_nxt_disp_on = 1'b1;
            end else if (!r_horiz) begin
              if (r_byte_data[7:2] == 6'b101100) begin
                w_nxt_page = r_byte_data[1:0];
              end else if (r_byte_data[7:4] == 4'h0) begin
                w_nxt_col = {r_col[6:4], r_byte_data[3:0]};
              end else if (r_byte_data[7:4] == 4'h1) begin
                w_nxt_col = {r_byte_data[2:0], r_col[3:0]};
              end
            end
          end
          ST_ARG1: begin
            if (r_op == CMD_MEM_MODE) begin
              w_nxt_horiz = (r_byte_data[1:0] != 2'd2);
            end else if (r_op == CMD_COL_ADDR || r_op == CMD_PAGE_ADDR) begin
              w_nxt_arg1  = r_byte_data[6:0];
              w_nxt_state = ST_ARG2;
            end
          end
          ST_ARG2: begin
            // Ranges commit together so an aborted command leaves them untouched.
            if (r_op == CMD_COL_ADDR) begin
              w_nxt_col_start = r_arg1;
              w_nxt_col_end   = r_byte_data[6:0];
              w_nxt_col       = r_arg1;
            end else begin
              w_nxt_page_start = r_arg1[1:0];
              w_nxt_page_end   = r_byte_data[1:0];
              w_nxt_page       = r_arg1[1:0];
            end
          end
          default: begin
            w_nxt_state = ST_IDLE;
          end
        endcase
      end
    end
  end

  oled_rx_framebuf u_framebuf (
    .clk     (clk),
    .rstn    (rstn),
    .we      (w_fb_we),
    .waddr   ({r_page, r_col}),
    .wdata   (r_byte_data),
    .raddr   (rd_addr),
    .rd_data (rd_data)
  );

  assign byte_valid   = r_byte_valid;
  assign byte_data    = r_byte_data;
  assign byte_is_data = r_byte_is_data;
  assign disp_on      = r_disp_on;
  assign frame_done   = w_frame_done;

`ifdef OLED_SPI_RX_STATS_EN
  logic [15:0] r_cmd_count;
  logic [15:0] r_data_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmd_count  <= 16'd0;
      r_data_count <= 16'd0;
    end else if (r_byte_valid) begin
      if (r_byte_is_data) begin
        if (r_data_count != 16'hFFFF) r_data_count <= r_data_count + 16'd1;
      end else begin
        if (r_cmd_count != 16'hFFFF) r_cmd_count <= r_cmd_count + 16'd1;
      end
    end
  end

  assign cmd_count  = r_cmd_count;
  assign data_count = r_data_count;
`else
  // Byte statistics are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_spi_rx
// Brief    : Self-checking bench for oled_spi_rx with a frame-buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oled_spi_rx;

  localparam int IDLE_CLKS = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       oled_sclk = 1'b1;
  logic       oled_sdin = 1'b0;
  logic       oled_dc = 1'b0;
  logic       oled_res = 1'b1;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic       disp_on;
  logic       frame_done;
  logic [8:0] rd_addr = 9'd0;
  logic [7:0] rd_data;
`ifdef OLED_SPI_RX_STATS_EN
  logic [15:0] cmd_count;
  logic [15:0] data_count;
`endif

  oled_spi_rx #(.IDLE_CLKS(IDLE_CLKS)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .oled_sclk    (oled_sclk),
    .oled_sdin    (oled_sdin),
    .oled_dc      (oled_dc),
    .oled_res     (oled_res),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .disp_on      (disp_on),
    .frame_done   (frame_done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
`ifdef OLED_SPI_RX_STATS_EN
    ,
    .cmd_count    (cmd_count),
    .data_count   (data_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event monitor: byte counts and the data-byte index of every frame_done.
  int bv_cnt = 0;
  int dv_cnt = 0;
  int fd_q[$];
  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt++;
      if (byte_is_data) dv_cnt++;
    end
    if (frame_done) fd_q.push_back(dv_cnt);
  end

  // Reference model: display geometry as plain integers.
  logic [7:0] m_fb [512];
  int m_horiz, m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_fd;
  logic m_disp;

  task automatic m_reset();
    m_horiz = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 3;
    m_col = 0; m_page = 0; m_disp = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc, input int half);
    for (int i = 7; i > 7 - n; i--) begin
      oled_sclk = 1'b0;
      oled_sdin = b[i];
      oled_dc   = dc;
      repeat (half) @(negedge clk);
      oled_sclk = 1'b1;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc, 2);
    repeat (6) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic data(input logic [7:0] b, output int a);
    a = m_page * 128 + m_col;
    send_byte(b, 1'b1);
    m_fb[a] = b;
    if (m_col == m_ce) begin
      m_col = m_cs;
      if (m_horiz != 0) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_fd++;
        end else begin
          m_page = (m_page + 1) % 4;
        end
      end
    end else begin
      m_col = (m_col + 1) % 128;
    end
  endtask

  task automatic window(input int cs, input int ce, input int ps, input int pe);
    cmd(8'h21); cmd(8'(cs)); cmd(8'(ce));
    cmd(8'h22); cmd(8'(ps)); cmd(8'(pe));
    m_cs = cs; m_ce = ce; m_col = cs;
    m_ps = ps; m_pe = pe; m_page = ps;
  endtask

  task automatic read_fb(input int addr, output logic [7:0] v);
    rd_addr = 9'(addr);
    @(negedge clk);
    @(negedge clk);
    v = rd_data;
  endtask

  initial begin
    int         b0, d0, f0, a, n;
    logic [7:0] v, marg, arg;
    logic [6:0] cs, ce, rc;
    logic [1:0] ps, pe, rp;
    int         addrs[$];

    m_reset();
    m_fd = 0;
    repeat (3) @(negedge clk);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_is_data", byte_is_data, 0);
    check("rst_disp_on", disp_on, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rd_data", rd_data, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Display-on at clk/8.
    b0 = bv_cnt;
    send_bits(8'hAF, 8, 1'b0, 4);
    repeat (6) @(negedge clk);
    m_disp = 1'b1;
    check("af_count", bv_cnt - b0, 1);
    check("af_data", byte_data, 8'hAF);
    check("af_is_data", byte_is_data, 0);
    check("af_disp_on", disp_on, 1);

    // Full-screen horizontal fill.
    cmd(8'h20); cmd(8'h00); m_horiz = 1;
    window(0, 127, 0, 3);
    f0 = fd_q.size(); d0 = dv_cnt;
    for (int i = 0; i < 512; i++) data(8'(i), a);
    check("fill_fd_count", fd_q.size() - f0, 1);
    check("fill_fd_index", fd_q[fd_q.size() - 1], d0 + 512);
    read_fb(9'h000, v); check("fill_000", v, 8'h00);
    read_fb(9'h07F, v); check("fill_07f", v, 8'h7F);
    read_fb(9'h1FF, v); check("fill_1ff", v, 8'hFF);

    // Small window wrapping inside one page.
    window(10, 11, 2, 2);
    f0 = fd_q.size(); d0 = dv_cnt;
    for (int i = 0; i < 5; i++) data(8'hA1 + 8'(i), a);
    check("win_fd_count", fd_q.size() - f0, 2);
    check("win_fd_first", fd_q[fd_q.size() - 2], d0 + 2);
    check("win_fd_second", fd_q[fd_q.size() - 1], d0 + 4);
    read_fb(9'h10A, v); check("win_10a", v, 8'hA5);
    read_fb(9'h10B, v); check("win_10b", v, 8'hA4);

    // Idle resynchronisation discards a partial byte.
    b0 = bv_cnt;
    send_bits(8'hE0, 3, 1'b0, 2);
    repeat (IDLE_CLKS + 1) @(negedge clk);
    send_byte(8'h55, 1'b0);
    check("idle_count", bv_cnt - b0, 1);
    check("idle_data", byte_data, 8'h55);

    // Data byte aborts a pending 0x21; 0xAE must then act as a command.
    cmd(8'h21);
    data(8'h3C, a);
    check("abort_addr", a, 9'h10B);
    cmd(8'hAE); m_disp = 1'b0;
    check("abort_idle_disp", disp_on, m_disp);
    data(8'h3D, a);
    read_fb(9'h10B, v); check("abort_3c", v, 8'h3C);
    read_fb(9'h10A, v); check("abort_3d", v, 8'h3D);
    check("abort_fd_total", fd_q.size(), m_fd);

    // Randomised rounds against the model.
    for (int r = 0; r < 4; r++) begin
      marg = 8'($urandom);
      if (r == 1 || r == 3) marg[1:0] = 2'd2;
      cmd(8'h20); cmd(marg);
      m_horiz = (marg[1:0] != 2'd2) ? 1 : 0;
      cs = 7'($urandom); ce = 7'($urandom); ps = 2'($urandom); pe = 2'($urandom);
      window(int'(cs), int'(ce), int'(ps), int'(pe));
      if (m_horiz == 0) begin
        rp = 2'($urandom); rc = 7'($urandom);
        cmd({6'b101100, rp}); cmd({4'h0, rc[3:0]}); cmd({5'b00010, rc[6:4]});
        m_page = int'(rp); m_col = int'(rc);
      end
      arg = 8'hAE | 8'($urandom_range(0, 1));
      cmd(8'h81); cmd(arg);
      check("rnd_ignored_arg_disp", disp_on, m_disp);
      n = $urandom_range(20, 40);
      addrs.delete();
      for (int i = 0; i < n; i++) begin
        data(8'($urandom), a);
        addrs.push_back(a);
      end
      check("rnd_fd_total", fd_q.size(), m_fd);
      foreach (addrs[k]) begin
        read_fb(addrs[k], v);
        check("rnd_fb", v, m_fb[addrs[k]]);
      end
    end

    // Display reset in the middle of a data byte.
    cmd(8'hAF); m_disp = 1'b1;
    cmd(8'h21); cmd(8'd5); cmd(8'd5);
    m_cs = 5; m_ce = 5; m_col = 5;
    b0 = bv_cnt;
    send_bits(8'h99, 4, 1'b1, 2);
    oled_res = 1'b0;
    repeat (8) @(negedge clk);
    oled_res = 1'b1;
    repeat (6) @(negedge clk);
    m_reset();
    check("res_no_byte", bv_cnt - b0, 0);
    check("res_disp_off", disp_on, 0);
    data(8'h77, a);
    data(8'h78, a);
    read_fb(9'h000, v); check("res_ptr_origin", v, 8'h77);
    read_fb(9'h001, v); check("res_ptr_next", v, 8'h78);
    read_fb(9'h10A, v); check("res_fb_kept", v, m_fb[9'h10A]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
